// File: rtl/input_buffer_if.sv
// Handshake bundle between an input_buffer and its upstream link / arbiter.
// master drives flits and pop requests; slave is the buffer itself.
interface input_buffer_if #(
  parameter int unsigned FLIT_WIDTH = 32,
  parameter int unsigned DEPTH      = 4
) ();
  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic [FLIT_WIDTH-1:0] ib_data_i;
  logic                  ib_write_i;
  logic                  ib_read_i;
  logic [FLIT_WIDTH-1:0] ib_data_o;
  logic [7:0]            ib_yx_addr_header_o;
  logic                  ib_header_valid_o;
  logic                  ib_empty_o;
  logic                  ib_full_o;
  logic [CntW-1:0]       ib_count_o;
  logic                  ib_credit_o;
  logic                  ib_overflow_o;
  logic                  ib_underflow_o;

  modport master (
    output ib_data_i, ib_write_i, ib_read_i,
    input  ib_data_o, ib_yx_addr_header_o, ib_header_valid_o, ib_empty_o, ib_full_o,
           ib_count_o, ib_credit_o, ib_overflow_o, ib_underflow_o
  );

  modport slave (
    input  ib_data_i, ib_write_i, ib_read_i,
    output ib_data_o, ib_yx_addr_header_o, ib_header_valid_o, ib_empty_o, ib_full_o,
           ib_count_o, ib_credit_o, ib_overflow_o, ib_underflow_o
  );
endinterface

// File: rtl/input_buffer.sv
// Per-port router flit FIFO: first-word fall-through head, packet-aware YX header
// register for the arbiter, one credit per popped flit, sticky over/underflow flags.
module input_buffer #(
  parameter int unsigned FLIT_WIDTH = 32,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned PKT_LEN    = 4
) (
  input logic           clk,
  input logic           reset,
  input_buffer_if.slave ib
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned CW = (PKT_LEN > 2) ? $clog2(PKT_LEN) : 1;

  typedef enum logic {HdrWait, HdrHold} hdr_state_e;

  logic [FLIT_WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]         wr_ptr_q, rd_ptr_q, count;
  logic [CW-1:0]         rd_flit_cnt_q;
  logic [FLIT_WIDTH-1:0] head;
  logic                  rd_acc, wr_acc, empty, full, last_flit;

  hdr_state_e            state_q;
  logic [7:0]            hdr_q;
  logic                  hdr_valid_q;
  logic                  credit_q;
  logic                  overflow_q;
  logic                  underflow_q;

  // Extra pointer MSB lets the difference range over 0..DEPTH.
  assign count     = wr_ptr_q - rd_ptr_q;
  assign empty     = (count == '0);
  assign full      = (count == PW'(DEPTH));
  assign rd_acc    = ib.ib_read_i & ~empty;
  assign wr_acc    = ib.ib_write_i & (~full | rd_acc);
  assign head      = mem_q[rd_ptr_q[AW-1:0]];
  assign last_flit = (rd_flit_cnt_q == CW'(PKT_LEN - 1));

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem_q[wr_ptr_q[AW-1:0]] <= ib.ib_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      rd_flit_cnt_q <= '0;
    end else begin
      if (wr_acc) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (rd_acc) begin
        rd_ptr_q      <= rd_ptr_q + PW'(1);
        rd_flit_cnt_q <= last_flit ? '0 : rd_flit_cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= HdrWait;
      hdr_q       <= 8'h00;
      hdr_valid_q <= 1'b0;
      credit_q    <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      credit_q <= rd_acc;
      if (ib.ib_write_i & ~wr_acc) overflow_q <= 1'b1;
      if (ib.ib_read_i & empty)    underflow_q <= 1'b1;
      unique case (state_q)
        HdrWait: begin
          if (~empty && rd_flit_cnt_q == '0) begin
            hdr_q       <= head[FLIT_WIDTH-1 -: 8];
            hdr_valid_q <= 1'b1;
            state_q     <= HdrHold;
          end
        end
        HdrHold: begin
          if (rd_acc && last_flit) begin
            hdr_valid_q <= 1'b0;
            state_q     <= HdrWait;
          end
        end
        default: begin
          hdr_valid_q <= 1'b0;
          state_q     <= HdrWait;
        end
      endcase
    end
  end

  assign ib.ib_data_o           = head;
  assign ib.ib_yx_addr_header_o = hdr_q;
  assign ib.ib_header_valid_o   = hdr_valid_q;
  assign ib.ib_empty_o          = empty;
  assign ib.ib_full_o           = full;
  assign ib.ib_count_o          = count;
  assign ib.ib_credit_o         = credit_q;
  assign ib.ib_overflow_o       = overflow_q;
  assign ib.ib_underflow_o      = underflow_q;
endmodule

// File: doc/input_buffer.md
# input_buffer

Per-port flit FIFO that sits directly upstream of the arbiter, one instance for each of the N, S, W, E and L router inputs. It stores incoming flits and presents the head flit and the head packet's YX destination header to the arbiter, along with an empty flag. It pops one flit for each arbiter read grant and returns one credit upstream for every flit it pops. It also tracks packet boundaries so that the header output always belongs to the packet currently at the head.

## Interface
- FLIT_WIDTH, 32: flit width in bits. The YX header occupies bits [FLIT_WIDTH-1 -: 8] of a header flit.
- DEPTH, 4: FIFO depth in flits. Power of 2, minimum 2.
- PKT_LEN, 4: flits per packet, header included. Minimum 2.

- clk  input  1  router clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- ib_data_i  input  FLIT_WIDTH  incoming flit from the upstream link.
- ib_write_i  input  1  push request for ib_data_i.
- ib_read_i  input  1  pop request; driven by the arbiter's rrp_x_priority_read_o.
- ib_data_o  output  FLIT_WIDTH  head flit (first-word fall-through) for the crossbar.
- ib_yx_addr_header_o  output  8  registered YX destination of the head packet; goes to the arbiter's yx_x_addr_header_i.
- ib_header_valid_o  output  1  ib_yx_addr_header_o belongs to the packet currently at the head.
- ib_empty_o  output  1  FIFO holds 0 flits.
- ib_full_o  output  1  FIFO holds DEPTH flits.
- ib_count_o  output  $clog2(DEPTH)+1  occupancy.
- ib_credit_o  output  1  one-cycle credit-return pulse to the upstream router.
- ib_overflow_o  output  1  sticky: a write was dropped.
- ib_underflow_o  output  1  sticky: a read arrived while empty.

## Operation
- Storage is DEPTH entries. wr_ptr and rd_ptr are each $clog2(DEPTH)+1 bits and wrap naturally; the MSB distinguishes full from empty.
- Write acceptance: wr_acc = ib_write_i & (~ib_full_o | rd_acc).
- Read acceptance: rd_acc = ib_read_i & ~ib_empty_o. There is no bypass: a write into an empty FIFO cannot be read in the same cycle.
- Count update: ib_count_o += wr_acc − rd_acc. ib_empty_o = (count==0). ib_full_o = (count==DEPTH).
- Dropped writes: ib_write_i while full with no rd_acc is dropped, sets ib_overflow_o, and leaves the FIFO contents unchanged.
- Ignored reads: ib_read_i while empty is ignored and sets ib_underflow_o.
- Sticky flags ib_overflow_o and ib_underflow_o clear only on reset.
- ib_data_o = mem[rd_ptr] at all times. Its value is don't-care while empty.
- Packet tracking: rd_flit_cnt counts 0..PKT_LEN−1 and increments on each rd_acc, wrapping to 0 after PKT_LEN−1. The head flit is a header iff rd_flit_cnt==0.
- Header FSM has two states:
  - HDR_WAIT: ib_header_valid_o=0. When ~ib_empty_o & rd_flit_cnt==0, capture head flit [FLIT_WIDTH-1 -: 8] into ib_yx_addr_header_o and go to HDR_HOLD.
  - HDR_HOLD: ib_header_valid_o=1 and the header value is held through the whole packet. On the rd_acc that pops the last flit (rd_flit_cnt==PKT_LEN−1), go to HDR_WAIT. The next packet's header is then captured in the following cycle if it is already present.
- Credit: ib_credit_o is registered and equals rd_acc from the previous cycle. That gives exactly one pulse per popped flit; back-to-back pops give a continuous high level.

## Timing
- Reset values: ib_empty_o=1, ib_full_o=0, ib_count_o=0, ib_yx_addr_header_o=8'h00, ib_header_valid_o=0, ib_credit_o=0, ib_overflow_o=0, ib_underflow_o=0, both pointers 0, rd_flit_cnt 0, FSM in HDR_WAIT.
- Write-to-visibility latency:
  - A flit written in cycle t appears on ib_data_o, with ib_empty_o=0, in cycle t+1.
  - If that flit is a header, it appears on ib_yx_addr_header_o with ib_header_valid_o=1 in cycle t+2.
- Read-to-credit latency: a pop in cycle t advances ib_data_o in t+1 and pulses ib_credit_o in t+1.
- Simultaneous read and write:
  - When full: both accepted, count stays DEPTH, ib_full_o stays 1, no overflow.
  - When empty: the write is accepted, the read is ignored, and ib_underflow_o is set.
- Wrap-around: pointers wrap from DEPTH−1 to 0 with no bubble, and full/empty stay correct across any number of wraps.
- Reset asserted mid-packet: all state returns to reset values in the next cycle, stored flits are discarded, and no credit pulse is emitted for them.

## Test plan
- Reset, then write header 32'hA5xx_xxxx followed by 3 body flits, one per cycle: ib_empty_o=0 in cycle 1, ib_yx_addr_header_o=8'hA5 with ib_header_valid_o=1 in cycle 2, ib_full_o=1 and ib_count_o=4 after cycle 4.
- FIFO full, 5th write with no read: ib_overflow_o=1, ib_count_o stays 4, ib_data_o is unchanged.
- FIFO full, read and write in the same cycle: ib_count_o stays 4, no overflow, ib_credit_o=1 next cycle, and the new flit appears at the head after 4 pops.
- Pop a full 4-flit packet while the next header 8'h3C is already queued: ib_header_valid_o drops for 1 cycle, then shows 8'h3C. Exactly 4 credit pulses are emitted.
- Read while empty and write 1 flit in the same cycle: ib_underflow_o=1, ib_count_o=1, no credit pulse.
- Reset asserted after 2 of 4 flits have been popped: all outputs return to reset values next cycle. A following fresh packet is tracked from rd_flit_cnt=0 and its header is captured correctly.
